// File: rtl/fp_adder_pkg.sv
// Shared types and constants for the sequential floating-point adder.
package fp_adder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } fsm_state_t;

    // Guard, round and sticky bits carried below the significand LSB.
    localparam int GRS_W = 3;

    // Quiet NaN: positive sign, all-ones exponent, only the fraction MSB set.
    localparam logic QNAN_SIGN     = 1'b0;
    localparam logic QNAN_FRAC_MSB = 1'b1;
    // Infinity and zero carry an all-zero fraction.
    localparam logic SPECIAL_FRAC_FILL = 1'b0;

endpackage

// File: rtl/fp_align_shift.sv
// Right shifter for operand alignment: keeps guard/round bits and ORs every
// bit shifted past the round position into the sticky bit.
module fp_align_shift
    import fp_adder_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W:0]       sig,
    input  logic [EXP_W-1:0]     shamt,
    output logic [MAN_W+GRS_W:0] shifted
);

    localparam int EXT_W = MAN_W + 1 + GRS_W;

    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] kept;
    logic [EXT_W-1:0] lost;
    logic [31:0]      shamt_w;

    assign ext     = {sig, {GRS_W{1'b0}}};
    assign shamt_w = 32'(shamt);
    assign kept    = ext >> shamt;

    generate
        for (genvar gi = 0; gi < EXT_W; gi++) begin : g_lost
            assign lost[gi] = ext[gi] && (32'(gi) < shamt_w);
        end
    endgenerate

    always_comb begin
        if (shamt_w >= 32'(EXT_W)) begin
            shifted = {{(EXT_W-1){1'b0}}, |sig};
        end else begin
            shifted = {kept[EXT_W-1:1], kept[0] | (|lost)};
        end
    end

endmodule

// File: rtl/fp_adder_seq.sv
// Multi-cycle IEEE-style adder (no subnormals). Rounding mode chosen at
// compile time: FP_ADD_RNE_EN defined -> round-nearest-even, else truncate.
module fp_adder_seq
    import fp_adder_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow
);

    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = SIG_W + GRS_W;
    localparam int SUM_W = EXT_W + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    fsm_state_t       state_reg;
    logic [W-1:0]     a_reg, b_reg;
    logic [EXT_W-1:0] big_ext_reg, small_ext_reg;
    logic [SUM_W-1:0] sum_reg;
    logic [EXP_W:0]   exp_reg;
    logic             sign_reg, eff_sub_reg, zero_reg;
    logic             in_ready_reg, out_valid_reg, overflow_reg;
    logic [W-1:0]     result_reg;

    logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp, exp_diff;
    logic [SIG_W-1:0] a_sig, b_sig, big_sig, small_sig;
    logic [EXT_W-1:0] small_ext;
    logic             a_is_big, big_sign;
    logic             a_exp_ones, b_exp_ones, special, special_nan;
    logic [W-1:0]     special_result;

    assign a_exp    = a_reg[W-2:MAN_W];
    assign b_exp    = b_reg[W-2:MAN_W];
    // A zero exponent (zero or subnormal) contributes a zero significand.
    assign a_sig    = (a_exp == '0) ? '0 : {1'b1, a_reg[MAN_W-1:0]};
    assign b_sig    = (b_exp == '0) ? '0 : {1'b1, b_reg[MAN_W-1:0]};
    assign a_is_big = a_reg[W-2:0] >= b_reg[W-2:0];

    assign big_exp   = a_is_big ? a_exp : b_exp;
    assign small_exp = a_is_big ? b_exp : a_exp;
    assign big_sig   = a_is_big ? a_sig : b_sig;
    assign small_sig = a_is_big ? b_sig : a_sig;
    assign big_sign  = a_is_big ? a_reg[W-1] : b_reg[W-1];
    assign exp_diff  = big_exp - small_exp;

    fp_align_shift #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_align (
        .sig    (small_sig),
        .shamt  (exp_diff),
        .shifted(small_ext)
    );

    assign a_exp_ones  = a_exp == EXP_ONES;
    assign b_exp_ones  = b_exp == EXP_ONES;
    assign special     = a_exp_ones || b_exp_ones;
    assign special_nan = (a_exp_ones && a_reg[MAN_W-1:0] != '0)
                      || (b_exp_ones && b_reg[MAN_W-1:0] != '0)
                      || (a_exp_ones && b_exp_ones && (a_reg[W-1] != b_reg[W-1]));
    assign special_result = special_nan
        ? {QNAN_SIGN, EXP_ONES, QNAN_FRAC_MSB, {(MAN_W-1){SPECIAL_FRAC_FILL}}}
        : (a_exp_ones ? a_reg : b_reg);

    logic             round_inc;
    logic [SIG_W:0]   mant_rnd;
    logic [EXP_W:0]   exp_rnd;
    logic [MAN_W-1:0] frac_rnd;

`ifdef FP_ADD_RNE_EN
    assign round_inc = sum_reg[2] && (sum_reg[1] || sum_reg[0] || sum_reg[GRS_W]);
`else
    assign round_inc = 1'b0;
`endif

    assign mant_rnd = {1'b0, sum_reg[EXT_W-1:GRS_W]} + (SIG_W+1)'(round_inc);
    assign exp_rnd  = exp_reg + (EXP_W+1)'(mant_rnd[SIG_W]);
    assign frac_rnd = mant_rnd[SIG_W] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (special) begin
                        result_reg    <= special_result;
                        overflow_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        big_ext_reg   <= {big_sig, {GRS_W{1'b0}}};
                        small_ext_reg <= small_ext;
                        sign_reg      <= big_sign;
                        eff_sub_reg   <= a_reg[W-1] ^ b_reg[W-1];
                        exp_reg       <= {1'b0, big_exp};
                        zero_reg      <= 1'b0;
                        state_reg     <= ADD;
                    end
                end
                ADD: begin
                    sum_reg   <= eff_sub_reg ? ({1'b0, big_ext_reg} - {1'b0, small_ext_reg})
                                             : ({1'b0, big_ext_reg} + {1'b0, small_ext_reg});
                    state_reg <= NORM;
                end
                NORM: begin
                    if (sum_reg[SUM_W-1]) begin
                        sum_reg   <= {1'b0, sum_reg[SUM_W-1:2], sum_reg[1] | sum_reg[0]};
                        exp_reg   <= exp_reg + 1'b1;
                        state_reg <= ROUND;
                    end else if (sum_reg[SUM_W-2]) begin
                        state_reg <= ROUND;
                    end else if (sum_reg == '0) begin
                        zero_reg  <= 1'b1;
                        sign_reg  <= 1'b0;
                        state_reg <= ROUND;
                    end else if (exp_reg <= (EXP_W+1)'(1)) begin
                        // Next shift would need exponent 0: flush, keeping the sign.
                        zero_reg  <= 1'b1;
                        state_reg <= ROUND;
                    end else begin
                        sum_reg <= sum_reg << 1;
                        exp_reg <= exp_reg - 1'b1;
                    end
                end
                ROUND: begin
                    if (zero_reg) begin
                        result_reg   <= {sign_reg, {(W-1){1'b0}}};
                        overflow_reg <= 1'b0;
                    end else if (exp_rnd >= {1'b0, EXP_ONES}) begin
                        result_reg   <= {sign_reg, EXP_ONES, {MAN_W{SPECIAL_FRAC_FILL}}};
                        overflow_reg <= 1'b1;
                    end else begin
                        result_reg   <= {sign_reg, exp_rnd[EXP_W-1:0], frac_rnd};
                        overflow_reg <= 1'b0;
                    end
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fp_adder_seq.sv
// Directed self-checking bench for fp_adder_seq (single precision defaults).
module tb_fp_adder_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;

    int total;
    int bad;

    fp_adder_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one operand pair, wait (bounded) for the result, then take it.
    // lat counts edges from the accept edge (1) to the edge raising out_valid.
    task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         output logic [31:0] res, output logic ovf, output int lat);
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        res = result;
        ovf = overflow;
        $display("op %h + %h -> %h ovf=%b lat=%0d", op_a, op_b, res, ovf, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_basic();
        logic [31:0] r; logic o; int l;
        do_op(32'h3F800000, 32'h3F800000, r, o, l);
        total++; if (r !== 32'h40000000) begin bad++; $display("FAIL one_plus_one: got %h want 40000000", r); end
        total++; if (o !== 1'b0) begin bad++; $display("FAIL one_plus_one_ovf: got %b want 0", o); end
        total++; if (l != 5) begin bad++; $display("FAIL one_plus_one_lat: got %0d want 5", l); end
        do_op(32'h3FC00000, 32'h3E800000, r, o, l);
        total++; if (r !== 32'h3FE00000) begin bad++; $display("FAIL diff_exp_add: got %h want 3FE00000", r); end
        total++; if (l != 5) begin bad++; $display("FAIL diff_exp_add_lat: got %0d want 5", l); end
        do_op(32'h3F800000, 32'hBF800000, r, o, l);
        total++; if (r !== 32'h00000000) begin bad++; $display("FAIL cancel_zero: got %h want 00000000", r); end
        total++; if (l != 5) begin bad++; $display("FAIL cancel_zero_lat: got %0d want 5", l); end
        do_op(32'hBFC00000, 32'h3E800000, r, o, l);
        total++; if (r !== 32'hBFA00000) begin bad++; $display("FAIL neg_sub: got %h want BFA00000", r); end
    endtask

    task automatic test_long_norm();
        logic [31:0] r; logic o; int l;
        do_op(32'h3F800000, 32'hBF7FFFFF, r, o, l);
        total++; if (r !== 32'h33800000) begin bad++; $display("FAIL long_norm: got %h want 33800000", r); end
        total++; if (l != 29) begin bad++; $display("FAIL long_norm_lat: got %0d want 29", l); end
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic o; int l;
        logic [31:0] want;
`ifdef FP_ADD_RNE_EN
        want = 32'h3F800002;
`else
        want = 32'h3F800001;
`endif
        do_op(32'h3F800001, 32'h33800000, r, o, l);
        total++; if (r !== want) begin bad++; $display("FAIL round_tie: got %h want %h", r, want); end
        total++; if (l != 5) begin bad++; $display("FAIL round_tie_lat: got %0d want 5", l); end
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic o; int l;
        do_op(32'h7F800000, 32'hFF800000, r, o, l);
        total++; if (r !== 32'h7FC00000) begin bad++; $display("FAIL inf_minus_inf: got %h want 7FC00000", r); end
        total++; if (o !== 1'b0) begin bad++; $display("FAIL inf_minus_inf_ovf: got %b want 0", o); end
        total++; if (l != 2) begin bad++; $display("FAIL inf_minus_inf_lat: got %0d want 2", l); end
        do_op(32'h3F800000, 32'hFF800000, r, o, l);
        total++; if (r !== 32'hFF800000) begin bad++; $display("FAIL one_plus_neg_inf: got %h want FF800000", r); end
        total++; if (l != 2) begin bad++; $display("FAIL one_plus_neg_inf_lat: got %0d want 2", l); end
        do_op(32'hFFC00001, 32'h3F800000, r, o, l);
        total++; if (r !== 32'h7FC00000) begin bad++; $display("FAIL nan_input: got %h want 7FC00000", r); end
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF, r, o, l);
        total++; if (r !== 32'h7F800000) begin bad++; $display("FAIL max_plus_max: got %h want 7F800000", r); end
        total++; if (o !== 1'b1) begin bad++; $display("FAIL max_plus_max_ovf: got %b want 1", o); end
        total++; if (l != 5) begin bad++; $display("FAIL max_plus_max_lat: got %0d want 5", l); end
    endtask

    task automatic test_backpressure();
        int cnt;
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Offer a different pair while busy; it must not be taken before IDLE.
        a = 32'h3FC00000;
        b = 32'h3E800000;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_wait: got out_valid %b want 1", out_valid); end
        for (int i = 0; i < 3; i++) begin
            $display("hold cycle %0d result=%h in_ready=%b", i, result, in_ready);
            total++; if (result !== 32'h40000000) begin bad++; $display("FAIL bp_hold_result: got %h want 40000000", result); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready: got %b want 0", in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_same_cycle_accept: got in_ready %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        $display("queued op result=%h", result);
        total++; if (result !== 32'h3FE00000) begin bad++; $display("FAIL bp_next_op: got %h want 3FE00000", result); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        // Leave overflow=1 from a previous op so the reset clear is visible.
        a = 32'h3F800000;
        b = 32'hBF7FFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        $display("reset in NORM: out_valid=%b in_ready=%b result=%h ovf=%b", out_valid, in_ready, result, overflow);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL mid_reset_result: got %h want 00000000", result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf: got %b want 0", overflow); end
        seen = 1'b0;
        repeat (35) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_discard: got out_valid seen %b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic o; int l;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
        do_op(32'h40000000, 32'h40400000, r, o, l);
        total++; if (r !== 32'h40A00000) begin bad++; $display("FAIL b2b_first: got %h want 40A00000", r); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
        do_op(32'h40A00000, 32'hC0000000, r, o, l);
        total++; if (r !== 32'h40400000) begin bad++; $display("FAIL b2b_second: got %h want 40400000", r); end
        total++; if (l != 6) begin bad++; $display("FAIL b2b_second_lat: got %0d want 6", l); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_long_norm();
        test_rounding();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_adder_seq.md
FP_ADDER_SEQ -- requirements
Module: fp_adder_seq

Interface
REQ-001 The block SHALL take parameter EXP_W, default 8, as the exponent field width.
REQ-002 The block SHALL take parameter MAN_W, default 23, as the stored fraction width; operand width W = 1+EXP_W+MAN_W.
REQ-003 Port clk SHALL be input, 1 bit, the sole clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit, a synchronous active-high reset.
REQ-005 Port in_valid SHALL be input, 1 bit, meaning operands are offered.
REQ-006 Port in_ready SHALL be output, 1 bit, meaning the block accepts operands this cycle.
REQ-007 Ports a and b SHALL be inputs, W bits each, as IEEE-style {sign, exponent, fraction} operands.
REQ-008 Port out_valid SHALL be output, 1 bit, meaning result is valid.
REQ-009 Port out_ready SHALL be input, 1 bit, meaning the consumer takes the result.
REQ-010 Port result SHALL be output, W bits, the sum a+b.
REQ-011 Port overflow SHALL be output, 1 bit, set with result when the sum overflowed to infinity.

Function
REQ-012 The FSM SHALL have states IDLE, ALIGN, ADD, NORM, ROUND and DONE.
REQ-013 Accept SHALL occur on in_valid&&in_ready; in_ready SHALL be 1 only in IDLE; operands are registered at accept.
REQ-014 ALIGN SHALL swap operands so the larger magnitude is first, then right-shift the smaller significand (hidden bit 1 prepended) by the exponent difference into MAN_W+1 bits plus guard, round and sticky bits, and OR all shifted-out bits into sticky; shifts >= MAN_W+4 yield only sticky.
REQ-015 ADD SHALL add significands on equal signs and subtract smaller from larger on unequal signs, with one carry bit; result sign is the larger operand's sign.
REQ-016 NORM SHALL do one action per cycle: carry set -> right-shift 1, exponent+1, sticky absorbs the lost bit, go ROUND; hidden bit set -> go ROUND; all bits zero -> result +0, go ROUND; else left-shift 1, exponent-1, stay.
REQ-017 An exponent reaching 0 in NORM SHALL flush to signed zero (no subnormal output); subnormal inputs SHALL be treated as zero.
REQ-018 ROUND SHALL apply the rounding mode of REQ-026; mantissa overflow from rounding SHALL increment the exponent.
REQ-019 An exponent reaching all-ones SHALL give signed infinity with overflow=1.
REQ-020 Either input exponent all-ones SHALL skip from ALIGN straight to DONE with: NaN 0x7FC00000-equivalent (sign 0, exponent all-ones, fraction MSB only) if any NaN or Inf+(-Inf), else that infinity; overflow=0.
REQ-021 Latency SHALL be: out_valid asserted 5+L cycles after the accept edge, L = NORM left-shift count; special cases 2 cycles.
REQ-022 In DONE out_valid=1 and result/overflow SHALL hold stable until out_valid&&out_ready, then go to IDLE; no new accept in the same cycle.

Reset
REQ-023 rst SHALL force IDLE, out_valid=0, result=0, overflow=0, in_ready=1 on the next edge, from any state, discarding an in-flight operation.
REQ-024 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-025 Macro FP_ADD_RNE_EN SHALL select the rounding mode at compile time.
REQ-026 With FP_ADD_RNE_EN defined, ROUND SHALL round to nearest, ties to even (guard, round|sticky, LSB); without it, ROUND SHALL truncate; latency identical in both.

Structure
REQ-027 Package fp_adder_pkg SHALL hold the FSM state enum, the guard/round/sticky width constant (3) and the special-value field constants.
REQ-028 A sub-module fp_align_shift SHALL implement the sticky-preserving right shifter of REQ-014.

Verification
REQ-029 0x3F800000+0x3F800000 -> result 0x40000000, overflow 0, out_valid 5 cycles after accept.
REQ-030 0x3FC00000+0x3E800000 -> 0x3FE00000; 0x3F800000+0xBF800000 -> 0x00000000.
REQ-031 0x3F800000+0xBF7FFFFF -> 0x33800000 after L=24, out_valid 29 cycles after accept.
REQ-032 0x3F800001+0x33800000 -> 0x3F800002 with FP_ADD_RNE_EN, 0x3F800001 without.
REQ-033 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow 1; 0x7F800000+0xFF800000 -> 0x7FC00000 after 2 cycles.
REQ-034 out_ready held 0 for 3 cycles in DONE -> result stable, in_ready 0; rst asserted in NORM -> IDLE next edge, out_valid 0.
